// File: rtl/cordic_pkg.sv
// Shared CORDIC constants for the pol2rec/rec2pol pair: angle table, gain, angle limits, FSM states.
package cordic_pkg;

    localparam int ZG = 2;        // fractional guard bits on the angle accumulator
    localparam int ZW = 32 + ZG;  // z is Q16.18 degrees

    // 1/prod(sqrt(1+2^-2i)), unsigned Q1.31
    localparam logic [31:0] CORDIC_K = 32'd1304065748;

    localparam logic signed [31:0] ANG_90   = 32'sh005A_0000;
    localparam logic signed [31:0] ANG_180  = 32'sh00B4_0000;
    localparam logic signed [31:0] ANG_M180 = 32'shFF4C_0000;

    typedef enum logic [1:0] {S_IDLE, S_PRESCALE, S_ROTATE, S_DONE} state_e;

    // atan(2^-i) in degrees, Q16.18
    localparam logic signed [ZW-1:0] ATAN_TAB [0:29] = '{
        34'sd11796480, 34'sd6963869, 34'sd3679517, 34'sd1867780, 34'sd937515,
        34'sd469214,   34'sd234664,  34'sd117339,  34'sd58671,   34'sd29335,
        34'sd14668,    34'sd7334,    34'sd3667,    34'sd1833,    34'sd917,
        34'sd458,      34'sd229,     34'sd115,     34'sd57,      34'sd29,
        34'sd14,       34'sd7,       34'sd4,       34'sd2,       34'sd1,
        34'sd0,        34'sd0,       34'sd0,       34'sd0,       34'sd0
    };

    function automatic logic signed [ZW-1:0] atan_lut(input logic [4:0] i);
        if (i > 5'd29) return '0;
        return ATAN_TAB[i];
    endfunction

endpackage

// File: rtl/cordic_rot_stage.sv
// One combinational CORDIC micro-rotation in rotation mode; direction follows the sign of z.
module cordic_rot_stage
    import cordic_pkg::*;
#(
    parameter int XW = 36
) (
    input  logic signed [XW-1:0] x_i,
    input  logic signed [XW-1:0] y_i,
    input  logic signed [ZW-1:0] z_i,
    input  logic [4:0]           i_i,
    output logic signed [XW-1:0] x_o,
    output logic signed [XW-1:0] y_o,
    output logic signed [ZW-1:0] z_o
);

    logic signed [XW-1:0] xs, ys;
    logic signed [ZW-1:0] at;

    assign xs = x_i >>> i_i;
    assign ys = y_i >>> i_i;
    assign at = atan_lut(i_i);

    always_comb begin
        if (!z_i[ZW-1]) begin
            x_o = x_i - ys;
            y_o = y_i + xs;
            z_o = z_i - at;
        end else begin
            x_o = x_i + ys;
            y_o = y_i - xs;
            z_o = z_i + at;
        end
    end

endmodule

// File: rtl/pol2rec.sv
// Iterative polar-to-rectangular converter: {MOD, ANG} -> {RE, IM}, one micro-rotation per cycle.
module pol2rec
    import cordic_pkg::*;
#(
    parameter int N_ITER = 24,
    parameter int GUARD  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] in_pol,
    output logic [63:0] out_rect,
    output logic        busy,
    output logic        done,
    output logic        range_err
);

    localparam int XW  = 32 + GUARD + 2;
    localparam int IW  = 5;
    localparam int RND = 1 << (GUARD - 1);

    state_e               state_q, state_d;
    logic [31:0]          mod_q, mod_d;
    logic signed [31:0]   ang_q, ang_d;
    logic signed [XW-1:0] x_q, x_d, y_q, y_d, x_nx, y_nx;
    logic signed [ZW-1:0] z_q, z_d, z_nx;
    logic [IW-1:0]        it_q, it_d;
    logic                 err_q, err_d;
    logic [63:0]          out_q, out_d;
    logic                 busy_q, busy_d, done_q, done_d, rerr_q, rerr_d;

    logic [63:0]          prod;
    logic [31:0]          mk;
    logic signed [XW-1:0] mkx;
    logic                 prod_unused;

    // Prescale product K*mod_q as Q16.16 rounded on bit 30, then widened with guard bits
    assign prod        = 64'(mod_q) * 64'(CORDIC_K);
    assign mk          = prod[62:31] + {31'b0, prod[30]};
    assign mkx         = {2'b00, mk, {GUARD{1'b0}}};
    assign prod_unused = ^{prod[63], prod[29:0]};

    cordic_rot_stage #(.XW(XW)) u_stage (
        .x_i (x_q),
        .y_i (y_q),
        .z_i (z_q),
        .i_i (it_q),
        .x_o (x_nx),
        .y_o (y_nx),
        .z_o (z_nx)
    );

    function automatic logic [31:0] rnd_sat(input logic signed [XW-1:0] v);
        logic signed [XW:0] r, s;
        r = {v[XW-1], v} + (XW+1)'(RND);
        s = r >>> GUARD;
        if (s[XW:31] != {(XW-30){s[31]}}) return s[XW] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return s[31:0];
    endfunction

    always_comb begin
        state_d = state_q;
        mod_d   = mod_q;
        ang_d   = ang_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        it_d    = it_q;
        err_d   = err_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rerr_d  = rerr_q;
        case (state_q)
            S_IDLE: begin
                busy_d = start;
                if (start) begin
                    mod_d   = in_pol[63:32];
                    ang_d   = in_pol[31:0];
                    err_d   = in_pol[63] | ($signed(in_pol[31:0]) < ANG_M180) |
                              ($signed(in_pol[31:0]) > ANG_180);
                    state_d = err_d ? S_DONE : S_PRESCALE;
                end
            end
            S_PRESCALE: begin
                // fold |ANG| > 90 so the rotation stays inside CORDIC convergence
                if (ang_q > ANG_90) begin
                    x_d = '0;
                    y_d = mkx;
                    z_d = {ang_q - ANG_90, {ZG{1'b0}}};
                end else if (ang_q < -ANG_90) begin
                    x_d = '0;
                    y_d = -mkx;
                    z_d = {ang_q + ANG_90, {ZG{1'b0}}};
                end else begin
                    x_d = mkx;
                    y_d = '0;
                    z_d = {ang_q, {ZG{1'b0}}};
                end
                it_d    = '0;
                state_d = S_ROTATE;
            end
            S_ROTATE: begin
                x_d  = x_nx;
                y_d  = y_nx;
                z_d  = z_nx;
                it_d = it_q + 1'b1;
                if (it_q == IW'(N_ITER - 1)) state_d = S_DONE;
            end
            S_DONE: begin
                out_d   = err_q ? 64'h0 : {rnd_sat(x_q), rnd_sat(y_q)};
                rerr_d  = err_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            mod_q   <= '0;
            ang_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            it_q    <= '0;
            err_q   <= 1'b0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mod_q   <= mod_d;
            ang_q   <= ang_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            it_q    <= it_d;
            err_q   <= err_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rerr_q  <= rerr_d;
        end
    end

    assign out_rect  = out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign range_err = rerr_q;

endmodule

// File: doc/pol2rec.md
# pol2rec

Polar-to-rectangular converter: the inverse of the ALU's rec2pol path. It takes a packed polar word {MOD, ANG} and returns the packed rectangular word {RE, IM} using an iterative CORDIC in rotation mode, with a start/done handshake. It sits beside rec2pol under the ALU, so the ALU can round-trip between representations.

## Interface
- N_ITER, 24: CORDIC micro-rotations; legal range 16..30.
- GUARD, 2: extra fractional bits carried internally on x and y.
- clock  in  1  master clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  request pulse; sampled only in IDLE.
- in_pol  in  64  [63:32] MOD, unsigned Q16.16; [31:0] ANG, signed Q16.16 degrees.
- out_rect  out  64  [63:32] RE, [31:0] IM, both signed Q16.16; registered; reset 0.
- busy  out  1  high from the cycle after an accepted start through the done cycle; reset 0.
- done  out  1  single-cycle pulse when out_rect is valid; reset 0.
- range_err  out  1  sticky per operation; valid with done; reset 0.

## Operation
- States: IDLE, PRESCALE, ROTATE, DONE.
- IDLE: when start=1, capture in_pol into internal registers and go to PRESCALE. When start=0, stay in IDLE.
- Range check at capture. range_err=1 if ANG < -180.0 (0xFF4C0000) or ANG > +180.0 (0x00B40000), or if MOD[31]=1.
  - On error, skip PRESCALE and ROTATE: go straight to DONE with out_rect=0.
- PRESCALE (1 cycle): x = MOD*K rounded, where K = 0.6072529350 as unsigned Q1.31. y = 0.
  - Quadrant fold: if ANG > 90.0, set x = 0, y = MOD*K and z = ANG-90.0. If ANG < -90.0, set x = 0, y = -MOD*K and z = ANG+90.0. Otherwise z = ANG.
- ROTATE (N_ITER cycles, i = 0..N_ITER-1): d = sign(z).
  - If z >= 0: x -= y>>>i, y += x>>>i, z -= atan_tab[i].
  - If z < 0: x += y>>>i, y -= x>>>i, z += atan_tab[i].
  - All updates in a cycle use that cycle's old values.
- Width rule: x and y are signed 32+GUARD+2 bits (2 integer guard bits, GUARD fractional guard bits). z is signed 34 bits. Shifts are arithmetic.
- DONE (1 cycle): drop GUARD bits with round-half-up, saturate to signed 32 bits, register into out_rect, pulse done, return to IDLE.
- A start asserted while busy=1 is ignored and not queued.
- out_rect holds its value until the next done.

## Timing
- A start accepted at edge t gives PRESCALE at t+1..t+2 and ROTATE from t+2 for N_ITER cycles.
- done=1 and out_rect valid in cycle t+N_ITER+2. That is 26 cycles at the default.
- An error operation gives done in cycle t+1.
- busy drops with done. A new start sampled in the cycle after done is accepted, giving back-to-back throughput of one result per N_ITER+3 cycles.
- Reset mid-operation: next state IDLE, and busy, done, range_err and out_rect all go to 0. No done is emitted for the aborted operation.
- ANG = ±180.0 exactly is legal and folds to ±90 then ±90, so RE = -MOD and IM = 0 within tolerance.
- Accuracy: |error| <= 8 LSB per component for MOD <= 0x7FFFFFFF.

## Structure
- Package cordic_pkg holds:
  - atan_tab[0..29]: atan(2^-i) in degrees, signed Q16.16 with 2 guard bits.
  - CORDIC_K (Q1.31).
  - Constants ANG_90, ANG_180, ANG_M180.
  - State enum.
  - rec2pol is to share the same package.
- One sub-module, cordic_rot_stage: the combinational single micro-rotation (x, y, z, i in; x', y', z' out). pol2rec instantiates it once and iterates it.
- The prescale multiply is a single 32x32 unsigned product, of which only [62:31] is used.

## Test plan
- MOD=0x00010000, ANG=0 -> RE≈0x00010000, IM≈0x00000000 (±8 LSB); done at cycle t+26; range_err=0.
- MOD=0x00010000, ANG=0x005A0000 (90°) -> RE≈0, IM≈0x00010000.
- MOD=0x00020000, ANG=0xFF790000 (-135°) -> RE≈IM≈0xFFFE95F6.
- ANG=0x00B50000 (181°) -> done at t+1, range_err=1, out_rect=0. Separately, MOD=0x80000000 -> range_err=1.
- start pulsed again at t+5 during ROTATE -> ignored, one done only. A start in the cycle after done is accepted.
- reset at t+10 mid-ROTATE -> busy=0, out_rect=0, no done. A following start completes normally.
